int_seq: RTL and testbench

- Interrupt/reset sequencer. Produces the `irq` force-BRK request consumed by the instruction/cycle controller at opcode fetch.
- Consumes that controller's `sync` strobe to decide, at each instruction boundary, which source is serviced.
- Supplies the vector address, B flag and write-inhibit used by the BRK micro-sequence.
- Sits between the external `nmi_n`/`irq_n` pins, the P register's I flag and the 6502 control/fetch logic.

---
 rtl/int_seq.sv | 128 ++++++++++++
 tb/tb_int_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_seq.sv
// Interrupt/reset sequencer: synchronizes the NMI/IRQ pins, arbitrates RES > NMI > IRQ
// at each opcode fetch, and supplies vector address, B flag and write-inhibit to BRK.
module int_seq #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] NMI_VEC     = 16'hFFFA,
    parameter logic [15:0] RES_VEC     = 16'hFFFC,
    parameter logic [15:0] IRQ_VEC     = 16'hFFFE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        iflag,
    input  logic        sync,
    input  logic        vec_done,
    output logic        irq,
    output logic [1:0]  svc_src,
    output logic [15:0] vec_addr,
    output logic        bflag,
    output logic        wr_inhibit,
    output logic        nmi_pend
);

    typedef enum logic {
        IDLE,
        SVC
    } state_t;

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_IRQ  = 2'b01;
    localparam logic [1:0] SRC_NMI  = 2'b10;
    localparam logic [1:0] SRC_RES  = 2'b11;

    logic [SYNC_STAGES-1:0] nmi_sync_q;
    logic [SYNC_STAGES-1:0] irq_sync_q;
    logic                   nmi_prev_q;

    state_t     state_q, state_d;
    logic [1:0] src_q, src_d;
    logic       res_pend_q, res_pend_d;
    logic       nmi_pend_q, nmi_pend_d;

    logic nmi_s;
    logic irq_s;
    logic nmi_edge;
    logic irq_act;
    logic irq_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            nmi_sync_q <= '1;
            irq_sync_q <= '1;
            nmi_prev_q <= 1'b1;
        end else begin
            nmi_sync_q <= {nmi_sync_q[SYNC_STAGES-2:0], nmi_n};
            irq_sync_q <= {irq_sync_q[SYNC_STAGES-2:0], irq_n};
            nmi_prev_q <= nmi_s;
        end
    end

    assign nmi_s    = nmi_sync_q[SYNC_STAGES-1];
    assign irq_s    = irq_sync_q[SYNC_STAGES-1];
    assign nmi_edge = nmi_prev_q & ~nmi_s;
    // IRQ is a live level: if it goes away before capture, nothing is taken.
    assign irq_act  = ~irq_s & ~iflag;
    assign irq_req  = (state_q == IDLE) & (res_pend_q | nmi_pend_q | irq_act);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            src_q      <= SRC_NONE;
            res_pend_q <= 1'b1;
            nmi_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            res_pend_q <= res_pend_d;
            nmi_pend_q <= nmi_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        res_pend_d = res_pend_q;
        nmi_pend_d = nmi_pend_q;
        case (state_q)
            IDLE: begin
                if (sync && irq_req) begin
                    state_d = SVC;
                    if (res_pend_q) begin
                        src_d      = SRC_RES;
                        res_pend_d = 1'b0;
                    end else if (nmi_pend_q) begin
                        src_d      = SRC_NMI;
                        nmi_pend_d = 1'b0;
                    end else begin
                        src_d = SRC_IRQ;
                    end
                end
            end
            SVC: begin
                if (vec_done) begin
                    state_d = IDLE;
                    src_d   = SRC_NONE;
                end
            end
        endcase
        // A new edge coinciding with an NMI capture must not be lost.
        if (nmi_edge) begin
            nmi_pend_d = 1'b1;
        end
    end

    always_comb begin
        irq        = irq_req;
        svc_src    = (state_q == SVC) ? src_q : SRC_NONE;
        nmi_pend   = nmi_pend_q;
        bflag      = (svc_src == SRC_NONE);
        wr_inhibit = (svc_src == SRC_RES);
        case (svc_src)
            SRC_RES: vec_addr = RES_VEC;
            SRC_NMI: vec_addr = NMI_VEC;
            default: vec_addr = IRQ_VEC;
        endcase
    end

endmodule

// File: tb/tb_int_seq.sv
// Bench for int_seq: directed scenarios then randomized pins/strobes, every cycle
// compared against a pin-history/priority model of the sequencer.
module tb_int_seq;

    localparam int          S       = 2;
    localparam logic [15:0] NMI_VEC = 16'hFFFA;
    localparam logic [15:0] RES_VEC = 16'hFFFC;
    localparam logic [15:0] IRQ_VEC = 16'hFFFE;

    logic        clk = 1'b0;
    logic        rst, nmi_n, irq_n, iflag, sync, vec_done;
    logic        irq, bflag, wr_inhibit, nmi_pend;
    logic [1:0]  svc_src;
    logic [15:0] vec_addr;

    int vectors = 0;
    int miscompares = 0;

    // Model: pin sample histories (index 0 = newest) plus service bookkeeping.
    bit         nmi_hist[$];
    bit         irq_hist[$];
    bit         m_svc;
    logic [1:0] m_src;
    bit         m_res, m_nmi;

    int_seq #(
        .SYNC_STAGES(S), .NMI_VEC(NMI_VEC), .RES_VEC(RES_VEC), .IRQ_VEC(IRQ_VEC)
    ) dut (
        .clk(clk), .rst(rst), .nmi_n(nmi_n), .irq_n(irq_n), .iflag(iflag),
        .sync(sync), .vec_done(vec_done), .irq(irq), .svc_src(svc_src),
        .vec_addr(vec_addr), .bflag(bflag), .wr_inhibit(wr_inhibit), .nmi_pend(nmi_pend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        nmi_hist.delete();
        irq_hist.delete();
        for (int i = 0; i <= S; i++) begin
            nmi_hist.push_back(1'b1);
            irq_hist.push_back(1'b1);
        end
        m_svc = 1'b0;
        m_src = 2'b00;
        m_res = 1'b1;
        m_nmi = 1'b0;
    endtask

    function automatic bit exp_irq();
        return !m_svc && (m_res || m_nmi || (!irq_hist[S-1] && !iflag));
    endfunction

    task automatic model_edge();
        bit nmi_fell;
        bit req;
        if (rst) begin
            model_reset();
            return;
        end
        nmi_fell = nmi_hist[S] && !nmi_hist[S-1];
        req      = exp_irq();
        if (m_svc) begin
            if (vec_done) begin
                m_svc = 1'b0;
                m_src = 2'b00;
            end
        end else if (sync && req) begin
            m_svc = 1'b1;
            if (m_res) begin
                m_src = 2'b11;
                m_res = 1'b0;
            end else if (m_nmi) begin
                m_src = 2'b10;
                m_nmi = 1'b0;
            end else begin
                m_src = 2'b01;
            end
        end
        if (nmi_fell) m_nmi = 1'b1;
        nmi_hist.push_front(nmi_n);
        void'(nmi_hist.pop_back());
        irq_hist.push_front(irq_n);
        void'(irq_hist.pop_back());
    endtask

    task automatic check_all();
        logic [1:0]  e_src;
        logic [15:0] e_vec;
        e_src = m_svc ? m_src : 2'b00;
        e_vec = (e_src == 2'b11) ? RES_VEC : (e_src == 2'b10) ? NMI_VEC : IRQ_VEC;
        chk("irq", {15'd0, irq}, {15'd0, exp_irq()});
        chk("svc_src", {14'd0, svc_src}, {14'd0, e_src});
        chk("vec_addr", vec_addr, e_vec);
        chk("bflag", {15'd0, bflag}, {15'd0, (e_src == 2'b00)});
        chk("wr_inhibit", {15'd0, wr_inhibit}, {15'd0, (e_src == 2'b11)});
        chk("nmi_pend", {15'd0, nmi_pend}, {15'd0, m_nmi});
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            check_all();
        end
    endtask

    task automatic settle();
        #1;
        check_all();
    endtask

    task automatic pulse_sync();
        sync = 1'b1;
        cyc();
        sync = 1'b0;
    endtask

    task automatic pulse_vd();
        vec_done = 1'b1;
        cyc();
        vec_done = 1'b0;
    endtask

    initial begin
        model_reset();
        rst = 1'b1; nmi_n = 1'b1; irq_n = 1'b1; iflag = 1'b1; sync = 1'b0; vec_done = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc();
        chk("reset_irq", {15'd0, irq}, 16'd1);

        // Reset vector fetch
        pulse_sync();
        chk("res_src", {14'd0, svc_src}, 16'd3);
        chk("res_vec", vec_addr, 16'hFFFC);
        chk("res_wrinh", {15'd0, wr_inhibit}, 16'd1);
        chk("res_bflag", {15'd0, bflag}, 16'd0);
        cyc(2);
        pulse_vd();
        chk("res_done_src", {14'd0, svc_src}, 16'd0);
        chk("res_done_irq", {15'd0, irq}, 16'd0);

        // IRQ masking, then unmask
        irq_n = 1'b0;
        cyc(3);
        chk("irq_masked", {15'd0, irq}, 16'd0);
        iflag = 1'b0;
        settle();
        chk("irq_unmasked", {15'd0, irq}, 16'd1);
        pulse_sync();
        chk("irq_src", {14'd0, svc_src}, 16'd1);
        chk("irq_vec", vec_addr, 16'hFFFE);
        chk("irq_bflag", {15'd0, bflag}, 16'd0);
        pulse_vd();
        irq_n = 1'b1; iflag = 1'b1;
        cyc(3);

        // NMI edge latency and capture
        nmi_n = 1'b0;
        cyc();
        chk("nmi_lat1", {15'd0, nmi_pend}, 16'd0);
        cyc();
        chk("nmi_lat2", {15'd0, nmi_pend}, 16'd0);
        cyc();
        chk("nmi_lat3", {15'd0, nmi_pend}, 16'd1);
        cyc(2);
        chk("nmi_hold", {15'd0, nmi_pend}, 16'd1);
        pulse_sync();
        chk("nmi_src", {14'd0, svc_src}, 16'd2);
        chk("nmi_vec", vec_addr, 16'hFFFA);
        chk("nmi_taken", {15'd0, nmi_pend}, 16'd0);
        pulse_vd();
        cyc(3);
        chk("nmi_level_no_retrig", {15'd0, irq}, 16'd0);

        // Priority NMI over IRQ
        nmi_n = 1'b1;
        cyc(3);
        nmi_n = 1'b0;
        cyc(3);
        irq_n = 1'b0; iflag = 1'b0;
        cyc(3);
        pulse_sync();
        chk("prio_nmi", {14'd0, svc_src}, 16'd2);
        pulse_vd();
        pulse_sync();
        chk("prio_irq", {14'd0, svc_src}, 16'd1);
        pulse_vd();
        irq_n = 1'b1; iflag = 1'b1;
        cyc(3);

        // NMI edge while servicing IRQ
        nmi_n = 1'b1;
        cyc(3);
        irq_n = 1'b0; iflag = 1'b0;
        cyc(3);
        pulse_sync();
        chk("svc_irq_src", {14'd0, svc_src}, 16'd1);
        irq_n = 1'b1; iflag = 1'b1; nmi_n = 1'b0;
        cyc(4);
        chk("svc_nmi_pend", {15'd0, nmi_pend}, 16'd1);
        chk("svc_irq_low", {15'd0, irq}, 16'd0);
        pulse_vd();
        chk("post_svc_irq", {15'd0, irq}, 16'd1);
        pulse_sync();
        pulse_vd();

        // New NMI edge in the same cycle as an NMI capture
        nmi_n = 1'b1;
        cyc(3);
        nmi_n = 1'b0;
        cyc(3);
        nmi_n = 1'b1;
        cyc();
        nmi_n = 1'b0;
        cyc(2);
        pulse_sync();
        chk("coinc_src", {14'd0, svc_src}, 16'd2);
        chk("coinc_pend", {15'd0, nmi_pend}, 16'd1);
        pulse_vd();
        chk("coinc_irq", {15'd0, irq}, 16'd1);
        pulse_sync();
        chk("coinc_second", {14'd0, svc_src}, 16'd2);
        pulse_vd();
        cyc(2);

        // Software BRK
        pulse_sync();
        chk("brk_src", {14'd0, svc_src}, 16'd0);
        chk("brk_vec", vec_addr, 16'hFFFE);
        chk("brk_bflag", {15'd0, bflag}, 16'd1);
        chk("brk_irq", {15'd0, irq}, 16'd0);

        // Reset during service
        irq_n = 1'b0; iflag = 1'b0;
        cyc(3);
        pulse_sync();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_irq", {15'd0, irq}, 16'd1);
        chk("midrst_pend", {15'd0, nmi_pend}, 16'd0);
        chk("midrst_src", {14'd0, svc_src}, 16'd0);
        pulse_sync();
        chk("midrst_res", {14'd0, svc_src}, 16'd3);
        pulse_vd();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 7) == 0) nmi_n = ~nmi_n;
            if ($urandom_range(0, 5) == 0) irq_n = ~irq_n;
            if ($urandom_range(0, 9) == 0) iflag = ~iflag;
            if (m_svc) begin
                vec_done = ($urandom_range(0, 3) == 0);
                sync     = vec_done && ($urandom_range(0, 1) == 1);
            end else begin
                vec_done = 1'b0;
                sync     = ($urandom_range(0, 2) == 0);
            end
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
